// File: rtl/status_link_pkg.sv
// Shared definitions for the 24-bit status serial link (serializer and receiver).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package status_link_pkg;

    // Bits per status frame, LSB transmitted first.
    localparam int STATUS_W = 24;

    // Receiver framing states.
    typedef enum logic [1:0] {
        SYNC,   // not yet aligned: drop bits until a frame toggle
        SHIFT,  // collecting bits of the current frame
        WAIT    // frame complete: drop pad bits until the next toggle
    } rx_state_t;

endpackage

// File: rtl/status_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy-based full/empty.
// Latency: a pushed word is visible on dout the cycle after the push into an empty FIFO.
// Backpressure: push into a full FIFO is dropped unless a pop happens in the same cycle.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push, din     write request and data
//   pop           read request (ignored while empty)
//   dout          head entry; holds its last value while empty
//   full, empty   derived from level
//   level         occupancy 0..DEPTH
module status_fifo #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        din,
    input  logic                     pop,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     rd_ptr_nxt;
    logic              do_push;
    logic              do_pop;
    logic              head_from_din;
    logic              head_from_mem;

    always_comb begin
        full          = (level == LW'(DEPTH));
        empty         = (level == '0);
        do_pop        = pop & ~empty;
        do_push       = push & (~full | do_pop);
        rd_ptr_nxt    = rd_ptr + AW'(do_pop);
        // The head is the incoming word only when nothing else remains ahead of it.
        head_from_din = do_push & (level == LW'(do_pop));
        // After a pop with more than one entry queued, the next stored entry becomes head.
        head_from_mem = do_pop & (level > LW'(1));
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            dout   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_ptr_nxt;
            if (do_push && !do_pop) begin
                level <= level + LW'(1);
            end else if (do_pop && !do_push) begin
                level <= level - LW'(1);
            end
            if (head_from_din) begin
                dout <= din;
            end else if (head_from_mem) begin
                dout <= mem[rd_ptr_nxt];
            end
        end
    end

endmodule

// File: rtl/status_sipo_rx.sv
// Status link receiver: realigns on frame toggles, deserializes LSB-first frames into words, queues them.
// Latency: last bit sampled at edge N -> word_valid after edge N+1 when the queue was empty.
// Backpressure: word_valid/word_ready; a completed word arriving at a full queue is dropped and overflow sticks.
//
// Ports:
//   sys_clk, rst                   clock, asynchronous active-high reset
//   serial_in, bit_valid           serial data and its per-bit qualifier
//   frame_tgl                      level that toggles at each frame boundary
//   word_out, word_valid, word_ready   FWFT output handshake
//   frame_err                      one-cycle pulse when a partial frame is discarded
//   overflow                       sticky drop indicator
//   level                          queue occupancy
module status_sipo_rx
    import status_link_pkg::*;
#(
    parameter int DATA_W = STATUS_W,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 5
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    input  logic                     serial_in,
    input  logic                     bit_valid,
    input  logic                     frame_tgl,
    output logic [DATA_W-1:0]        word_out,
    output logic                     word_valid,
    input  logic                     word_ready,
    output logic                     frame_err,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    rx_state_t          state;
    logic [CNT_W-1:0]   bit_cnt;
    logic [DATA_W-1:0]  shreg;
    logic [DATA_W-1:0]  shreg_next;
    logic               tgl_q;
    logic               primed;
    logic               tgl_edge;
    logic               push;
    logic [DATA_W-1:0]  push_dat;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;

    always_comb begin
        // primed is low only on the first cycle after reset, so the initial
        // frame_tgl level is captured without being mistaken for a boundary.
        tgl_edge   = primed & (frame_tgl ^ tgl_q);
        shreg_next = shreg;
        shreg_next[bit_cnt] = serial_in;
        word_valid = ~fifo_empty;
        pop        = word_valid & word_ready;
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state     <= SYNC;
            bit_cnt   <= '0;
            shreg     <= '0;
            tgl_q     <= 1'b0;
            primed    <= 1'b0;
            frame_err <= 1'b0;
            push      <= 1'b0;
            push_dat  <= '0;
        end else begin
            tgl_q     <= frame_tgl;
            primed    <= 1'b1;
            frame_err <= 1'b0;
            push      <= 1'b0;
            if (tgl_edge) begin
                // Boundary wins over a coincident bit, which then starts the new frame.
                frame_err <= (state == SHIFT) && (bit_cnt != '0);
                state     <= SHIFT;
                if (bit_valid) begin
                    shreg   <= DATA_W'(serial_in);
                    bit_cnt <= CNT_W'(1);
                end else begin
                    shreg   <= '0;
                    bit_cnt <= '0;
                end
            end else if (state == SHIFT && bit_valid) begin
                if (bit_cnt == LAST_BIT) begin
                    push     <= 1'b1;
                    push_dat <= shreg_next;
                    shreg    <= '0;
                    bit_cnt  <= '0;
                    state    <= WAIT;
                end else begin
                    shreg   <= shreg_next;
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overflow <= 1'b1;
        end
    end

    status_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (sys_clk),
        .rst   (rst),
        .push  (push),
        .din   (push_dat),
        .pop   (pop),
        .dout  (word_out),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

endmodule

// File: tb/tb_status_sipo_rx.sv
// Randomized and directed bench for status_sipo_rx with a frame-level reference model and scoreboard.
// Latency: model queues a completed word one clock after its last bit, matching the receiver.
// Backpressure: word_ready is driven directly or randomized per cycle by a background process.
module tb_status_sipo_rx;

    localparam int DW    = 24;
    localparam int DEPTH = 4;

    logic          sys_clk = 1'b0;
    logic          rst = 1'b1;
    logic          serial_in = 1'b0;
    logic          bit_valid = 1'b0;
    logic          frame_tgl = 1'b0;
    logic          word_ready = 1'b1;
    logic [DW-1:0] word_out;
    logic          word_valid;
    logic          frame_err;
    logic          overflow;
    logic [2:0]    level;

    status_sipo_rx #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(5)) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .serial_in  (serial_in),
        .bit_valid  (bit_valid),
        .frame_tgl  (frame_tgl),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .level      (level)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A frame is a run of bits collected after a toggle; 24 collected bits make a word.
    // Outside a frame (before the first toggle, or after a full word) bits are dropped.
    logic          bits[$];
    logic [DW-1:0] exp_q[$];
    bit            collecting = 0;
    bit            m_primed = 0;
    logic          m_prev = 1'b0;
    bit            pend_vld = 0;
    logic [DW-1:0] pend_word = '0;
    int            mcount = 0;
    bit            m_err = 0;
    bit            m_ovf = 0;
    bit            edge_seen;
    bit            popped;

    always @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            bits.delete();
            exp_q.delete();
            collecting = 0;
            m_primed   = 0;
            m_prev     = 1'b0;
            pend_vld   = 0;
            mcount     = 0;
            m_err      = 0;
            m_ovf      = 0;
        end else begin
            popped = (mcount > 0) && word_ready;
            if (popped) mcount--;
            if (pend_vld) begin
                if (mcount == DEPTH) m_ovf = 1;
                else begin
                    mcount++;
                    exp_q.push_back(pend_word);
                end
            end
            pend_vld  = 0;
            m_err     = 0;
            edge_seen = m_primed && (frame_tgl != m_prev);
            m_prev    = frame_tgl;
            m_primed  = 1;
            if (edge_seen) begin
                if (collecting && bits.size() > 0) m_err = 1;
                bits.delete();
                collecting = 1;
            end
            if (bit_valid && collecting) begin
                bits.push_back(serial_in);
                if (bits.size() == DW) begin
                    for (int i = 0; i < DW; i++) pend_word[i] = bits[i];
                    pend_vld   = 1;
                    collecting = 0;
                    bits.delete();
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int            delivered = 0;
    int            err_count = 0;
    int            peak = 0;
    logic [DW-1:0] last_word = '0;
    logic [DW-1:0] got;

    always @(negedge sys_clk) begin
        chk("word_valid", word_valid, mcount != 0);
        chk("level", level, mcount);
        chk("frame_err", frame_err, m_err);
        chk("overflow", overflow, m_ovf);
        if (frame_err === 1'b1) err_count++;
        if (int'(level) > peak) peak = int'(level);
        if (word_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("word_unexpected", 1, 0);
            end else if (word_ready) begin
                got = exp_q.pop_front();
                chk("word_out", word_out, got);
                delivered++;
                last_word = word_out;
            end else begin
                chk("word_out_held", word_out, exp_q[0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    bit rand_ready = 0;
    always @(posedge sys_clk) begin
        if (rand_ready) begin
            #3;
            word_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic cyc();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic idle(input int n);
        bit_valid = 1'b0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        serial_in = b;
        cyc();
        bit_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [DW-1:0] w, input int gap_pct, input bit tgl_with_bit0);
        logic [DW-1:0] v;
        v = w;
        frame_tgl = ~frame_tgl;
        if (!tgl_with_bit0) cyc();
        for (int i = 0; i < DW; i++) begin
            while (i > 0 && int'($urandom_range(0, 99)) < gap_pct) idle(1);
            send_bit(v[i]);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    int d0;
    logic [DW-1:0] w5;

    initial begin
        // reset state
        #1;
        chk("reset_word_out", word_out, 0);
        chk("reset_word_valid", word_valid, 0);
        chk("reset_frame_err", frame_err, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_level", level, 0);
        cyc();
        rst = 1'b0;
        cyc();

        // aligned frame
        d0 = delivered;
        send_frame(24'hA5C3F1, 0, 0);
        idle(3);
        chk("aligned_count", delivered - d0, 1);
        chk("aligned_word", last_word, 24'hA5C3F1);

        // bits before the first toggle are dropped
        apply_reset();
        d0 = delivered; peak = 0;
        for (int i = 0; i < DW; i++) send_bit(1'b1);
        idle(2);
        send_frame(24'h000001, 0, 0);
        idle(3);
        chk("presync_count", delivered - d0, 1);
        chk("presync_word", last_word, 24'h000001);
        chk("presync_peak", peak, 1);

        // short frame discarded with a single error pulse
        d0 = delivered; err_count = 0;
        frame_tgl = ~frame_tgl; cyc();
        for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)));
        send_frame(24'h123456, 0, 0);
        idle(3);
        chk("short_err_pulses", err_count, 1);
        chk("short_count", delivered - d0, 1);
        chk("short_word", last_word, 24'h123456);

        // gaps mid-frame and a pad bit after bit 23
        d0 = delivered;
        send_frame(24'h654321, 30, 0);
        send_bit(1'b1);
        idle(1);
        send_frame(24'h00ABCD, 30, 0);
        idle(3);
        chk("gaps_count", delivered - d0, 2);
        chk("gaps_word", last_word, 24'h00ABCD);

        // full queue, then push and pop in the same cycle
        word_ready = 1'b0;
        for (int f = 1; f <= 4; f++) send_frame(DW'(f), 0, 0);
        idle(2);
        chk("full_level", level, 4);
        w5 = 24'h000005;
        frame_tgl = ~frame_tgl; cyc();
        for (int i = 0; i < DW; i++) send_bit(w5[i]);
        word_ready = 1'b1;
        cyc();
        word_ready = 1'b0;
        chk("pushpop_level", level, 4);
        chk("pushpop_overflow", overflow, 0);
        word_ready = 1'b1;
        idle(6);

        // overflow: five frames with no consumer
        apply_reset();
        d0 = delivered;
        word_ready = 1'b0;
        for (int f = 1; f <= 5; f++) send_frame(DW'(f), 10, 0);
        idle(2);
        chk("ovf_level", level, 4);
        chk("ovf_flag", overflow, 1);
        word_ready = 1'b1;
        idle(8);
        chk("ovf_drain_count", delivered - d0, 4);
        chk("ovf_last_word", last_word, 24'h000004);
        chk("ovf_sticky", overflow, 1);

        // reset mid-frame with queued data
        word_ready = 1'b0;
        send_frame(24'h0000AA, 0, 0);
        send_frame(24'h0000BB, 0, 0);
        frame_tgl = ~frame_tgl; cyc();
        for (int i = 0; i < 12; i++) send_bit(1'b1);
        rst = 1'b1;
        #1;
        chk("midrst_word_valid", word_valid, 0);
        chk("midrst_level", level, 0);
        chk("midrst_word_out", word_out, 0);
        chk("midrst_overflow", overflow, 0);
        chk("midrst_frame_err", frame_err, 0);
        cyc();
        rst = 1'b0;
        word_ready = 1'b1;
        cyc();

        // toggle coincident with a valid bit
        d0 = delivered;
        send_frame(24'hFEDCB1, 0, 1);
        idle(3);
        chk("coincident_count", delivered - d0, 1);
        chk("coincident_word", last_word, 24'hFEDCB1);

        // randomized traffic
        rand_ready = 1;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) < 2) begin
                frame_tgl = ~frame_tgl; cyc();
                for (int i = 0; i < int'($urandom_range(1, 23)); i++) send_bit(1'($urandom_range(0, 1)));
            end else begin
                send_frame(DW'($urandom), 20, 1'($urandom_range(0, 1)));
                for (int p = 0; p < int'($urandom_range(0, 2)); p++) send_bit(1'($urandom_range(0, 1)));
            end
            idle(int'($urandom_range(0, 3)));
        end
        rand_ready = 0;
        idle(2);
        word_ready = 1'b1;
        idle(20);
        chk("drain_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/status_sipo_rx.md
Name: status_sipo_rx

Overview:
- Downstream receiver for the 24-bit status serializer.
- Samples the serial status bit stream, qualified by its per-bit write enable, and realigns on the frame toggle.
- Reassembles each frame into a parallel word and queues it in a small FIFO.
- Feeds the motor-status consumer through a valid/ready interface; reports framing errors and buffer overflow.

Parameters:
- DATA_W, 24, bits per status frame; LSB transmitted first.
- DEPTH, 4, output FIFO entries; power of two, 2..16.
- CNT_W, 5, bit-counter width; must satisfy 2**CNT_W > DATA_W.

Ports:
- sys_clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- serial_in  in  1  serial status data.
- bit_valid  in  1  serial_in holds a valid bit this cycle.
- frame_tgl  in  1  level toggles once per frame boundary.
- word_out  out  DATA_W  head-of-FIFO status word.
- word_valid  out  1  word_out is valid.
- word_ready  in  1  consumer accepts word_out.
- frame_err  out  1  one-cycle pulse when a partial frame is discarded.
- overflow  out  1  sticky; a completed word was dropped because the FIFO was full.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, active-high) values:
  - word_out=0, word_valid=0, frame_err=0, overflow=0, level=0.
  - FSM=SYNC, bit_cnt=0, shift register=0, tgl_q=0.
- Sampling:
  - Inputs are sampled on the rising edge; the upstream drives them on the falling edge, which gives half a cycle of margin.
  - Edge detect is tgl_edge = frame_tgl ^ tgl_q, where tgl_q is a registered copy updated every cycle.
  - Exception: on the first cycle after reset deasserts, tgl_q loads frame_tgl and no edge is flagged.
- FSM states:
  - SYNC: discard all bits. On tgl_edge, go to SHIFT with bit_cnt=0.
  - SHIFT: on bit_valid, store the bit with shreg[bit_cnt]=serial_in and increment bit_cnt. When the bit at bit_cnt==DATA_W-1 is stored, the word is complete: push the assembled word, set bit_cnt=0, go to WAIT.
  - WAIT: ignore bit_valid (surplus/pad bits). On tgl_edge, go to SHIFT with bit_cnt=0.
- tgl_edge in SHIFT:
  - With bit_cnt=0: no error; stay in SHIFT.
  - With 0<bit_cnt<DATA_W: discard the partial word, pulse frame_err for 1 cycle, reset bit_cnt to 0, stay in SHIFT.
- Simultaneous tgl_edge and bit_valid: the edge is processed first, and the bit becomes bit 0 of the new frame. This applies in all states.
- Latency: last bit sampled at edge N → word_valid=1 after edge N+1, if the FIFO was empty. The word is registered into the FIFO; there is no combinational path from serial_in.
- FIFO (first-word-fall-through):
  - word_out/word_valid reflect the head entry.
  - Pop occurs when word_valid && word_ready.
  - Push into a full FIFO with no pop in the same cycle: the word is dropped, overflow is set and stays 1 until rst, FIFO contents are unchanged.
  - Full with push and pop in the same cycle: both take effect; level is unchanged; no overflow.
  - Empty: word_valid=0 and word_ready is ignored; word_out holds its last value.
- level:
  - Increments on push-only.
  - Decrements on pop-only.
  - Unchanged on both or neither.
  - Range 0..DEPTH.
- Pointers wrap modulo DEPTH. Full/empty are derived from level, not from pointer equality.
- Reset mid-frame or mid-FIFO: all partial and queued data is lost; the FSM returns to SYNC, so the first frame after reset is always discarded until a toggle is seen.
- bit_cnt never exceeds DATA_W-1. bit_valid in SYNC or WAIT has no effect on any counter.

Decomposition:
- Package status_link_pkg:
  - STATUS_W=24.
  - rx_state_t enum {SYNC, SHIFT, WAIT}.
  - Shared with the serializer for the frame width constant.
- Sub-module status_fifo (DATA_W, DEPTH):
  - Synchronous FWFT FIFO with push/pop/full/empty/level and async active-high rst.
  - Instantiated once.
- The FSM, edge detect and shift register stay in the top.

Test Plan:
- Aligned frame:
  - Stimulus: reset, toggle frame_tgl, then 24 consecutive valid bits of 0xA5C3F1, LSB first; word_ready=1.
  - Response: word_out=0xA5C3F1 with word_valid=1 for exactly 1 cycle, 1 cycle after the last bit edge; frame_err=0.
- Pre-sync discard:
  - Stimulus: 24 bits of 0xFFFFFF before any toggle, then a toggle and 0x000001.
  - Response: only 0x000001 is delivered; level peaks at 1.
- Short frame:
  - Stimulus: toggle, 10 bits, toggle, full frame 0x123456.
  - Response: frame_err pulses once at the second toggle; the only word delivered is 0x123456.
- Gaps and pad bits:
  - Stimulus: bit_valid deasserted randomly mid-frame, plus 1 extra pad bit after bit 23, then a toggle and the next frame 0x00ABCD.
  - Response: 0x654321, then 0x00ABCD; the pad bit is ignored.
- Back-pressure and overflow:
  - Stimulus: word_ready=0 while 5 frames (1..5) are sent.
  - Response: level=4; overflow=1 after the 5th frame. Raising word_ready then yields 1,2,3,4 in order and overflow stays 1.
- Boundary cases:
  - Push and pop in the same cycle at level=4: level stays 4 and overflow stays 0.
  - rst asserted mid-frame: outputs return to their reset values immediately.
  - Toggle coincident with bit_valid: that bit lands in word_out[0].
